// File: rtl/qd_pkg.sv
// qd_pkg: shared AB state encoding, direction constants and the x4 step decoder
package qd_pkg;
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;
  typedef struct packed {
    logic valid;
    logic dir;
    logic illegal;
  } step_t;
  function automatic logic [1:0] qd_pos(input logic [1:0] ab);
    return ab == AB_00 ? 2'd0 : ab == AB_10 ? 2'd1 : ab == AB_11 ? 2'd2 : 2'd3;
  endfunction
  function automatic step_t qd_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    s.illegal = (prev ^ cur) == 2'b11;
    s.valid = prev != cur && !s.illegal;
    s.dir = qd_pos(cur) == qd_pos(prev) + 2'd1 ? DIR_FWD : DIR_REV;
    return s;
  endfunction
endpackage

// File: rtl/qd_decoder_multi_channel.sv
// qd_channel: one encoder channel with sync, glitch filter, prime, x4 decode, counter, dir and sticky err
module qd_channel
  import qd_pkg::*;
#(
  parameter int COUNT_W = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a,
  input  logic               b,
  input  logic               clear,
  input  logic               err_clr,
  output logic [COUNT_W-1:0] count,
  output logic               dir,
  output logic               err
);
  logic [SYNC_STAGES-1:0] sa, sb, sv;
  logic [1:0] synced, cand, filt, prev;
  logic [3:0] run, run_n;
  logic primed, upd, accept;
  step_t st;
  assign synced = {sa[SYNC_STAGES-1], sb[SYNC_STAGES-1]};
  always_comb begin
    run_n = synced != cand ? 4'd1 : run >= 4'(FILT_LEN) ? run : run + 4'd1;
    accept = sv[SYNC_STAGES-1] && run_n >= 4'(FILT_LEN) && (!primed || synced != filt);
    st = qd_step(prev, filt);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sa <= '0;
      sb <= '0;
      sv <= '0;
      cand <= '0;
      run <= '0;
      filt <= '0;
      prev <= '0;
      primed <= 1'b0;
      upd <= 1'b0;
      count <= '0;
      dir <= DIR_REV;
      err <= 1'b0;
    end else begin
      sa <= {sa[SYNC_STAGES-2:0], a};
      sb <= {sb[SYNC_STAGES-2:0], b};
      sv <= {sv[SYNC_STAGES-2:0], 1'b1};
      if (sv[SYNC_STAGES-1]) begin
        cand <= synced;
        run <= run_n;
      end
      upd <= accept && primed;
      if (accept) begin
        filt <= synced;
        prev <= filt;
        primed <= 1'b1;
      end
      if (clear) count <= '0;
      else if (upd && st.valid) count <= st.dir ? count + COUNT_W'(1) : count - COUNT_W'(1);
      if (upd && st.valid) dir <= st.dir;
      err <= (upd && st.illegal) || (err && !err_clr);
    end
  end
endmodule

// File: rtl/qd_decoder_multi.sv
// qd_decoder_multi: N-channel x4 quadrature decoder with atomic snapshot bank
module qd_decoder_multi
  import qd_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int COUNT_W = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         enc_a,
  input  logic [N_CH-1:0]         enc_b,
  input  logic [N_CH-1:0]         clear,
  input  logic                    snap,
  input  logic                    err_clr,
  output logic [N_CH*COUNT_W-1:0] count,
  output logic [N_CH*COUNT_W-1:0] snapshot,
  output logic                    snap_valid,
  output logic [N_CH-1:0]         dir,
  output logic [N_CH-1:0]         err
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    qd_channel #(.COUNT_W(COUNT_W), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_ch (
      .clk(clk),
      .reset(reset),
      .a(enc_a[i]),
      .b(enc_b[i]),
      .clear(clear[i]),
      .err_clr(err_clr),
      .count(count[i*COUNT_W +: COUNT_W]),
      .dir(dir[i]),
      .err(err[i])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      snapshot <= '0;
      snap_valid <= 1'b0;
    end else begin
      if (snap) snapshot <= count;
      snap_valid <= snap;
    end
  end
endmodule
